// File: rtl/div_unit.sv
// Multi-cycle 32-bit divider for signed and unsigned operands, one quotient bit per clock.
// Uses restoring division on operand magnitudes, then applies the signs to the results.
module div_unit (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Start,
   input  logic        Signed,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        Busy,
   output logic        Done,
   output logic [31:0] Quotient,
   output logic [31:0] Remainder,
   output logic        DivByZero
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_dvd;
   logic [31:0] r_rem;
   logic [31:0] r_dvs;
   logic [4:0]  r_cnt;
   logic        r_neg_q;
   logic        r_neg_r;
   logic        r_dz;

   logic        w_load;
   logic        w_step;
   logic        w_fix;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [32:0] w_shift;
   logic [33:0] w_trial;
   logic        w_fits;

   assign w_a_mag = (Signed && A[31]) ? (~A + 32'd1) : A;
   assign w_b_mag = (Signed && B[31]) ? (~B + 32'd1) : B;

   // Shifted partial remainder can reach 33 bits; one extra bit holds the borrow.
   assign w_shift = {r_rem, r_dvd[31]};
   assign w_trial = {1'b0, w_shift} - {2'b00, r_dvs};
   assign w_fits  = ~w_trial[33];

   always_ff @(posedge Clk) begin
      if (Rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (Start) w_next = (B == 32'd0) ? S_FIX : S_CALC;
         S_CALC:  if (r_cnt == 5'd31) w_next = S_FIX;
         S_FIX:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_load = (r_state == S_IDLE) && Start;
      w_step = (r_state == S_CALC);
      w_fix  = (r_state == S_FIX);
      Busy   = (r_state != S_IDLE);
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_dvd     <= '0;
         r_rem     <= '0;
         r_dvs     <= '0;
         r_cnt     <= '0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_dz      <= 1'b0;
         Done      <= 1'b0;
         Quotient  <= '0;
         Remainder <= '0;
         DivByZero <= 1'b0;
      end else begin
         Done <= w_fix;
         if (w_load) begin
            r_neg_q <= Signed & (A[31] ^ B[31]);
            r_neg_r <= Signed & A[31];
            r_dz    <= (B == 32'd0);
            // On divide-by-zero the raw dividend is kept so it can be returned untouched.
            r_dvd   <= (B == 32'd0) ? A : w_a_mag;
            r_dvs   <= w_b_mag;
            r_rem   <= '0;
            r_cnt   <= '0;
         end
         if (w_step) begin
            r_dvd <= {r_dvd[30:0], w_fits};
            r_rem <= w_fits ? w_trial[31:0] : w_shift[31:0];
            r_cnt <= r_cnt + 5'd1;
         end
         if (w_fix) begin
            DivByZero <= r_dz;
            if (r_dz) begin
               Quotient  <= 32'hFFFF_FFFF;
               Remainder <= r_dvd;
            end else begin
               Quotient  <= r_neg_q ? (~r_dvd + 32'd1) : r_dvd;
               Remainder <= r_neg_r ? (~r_rem + 32'd1) : r_rem;
            end
         end
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table of divides plus reset and handshake sequences.
module tb_div_unit;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        Start = 1'b0;
   logic        Signed = 1'b0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        Busy;
   logic        Done;
   logic [31:0] Quotient;
   logic [31:0] Remainder;
   logic        DivByZero;

   int total = 0;
   int bad = 0;

   div_unit dut (
      .Clk(Clk), .Rst(Rst), .Start(Start), .Signed(Signed), .A(A), .B(B),
      .Busy(Busy), .Done(Done), .Quotient(Quotient), .Remainder(Remainder),
      .DivByZero(DivByZero)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
      int          lat;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      @(negedge Clk);
      Signed = sgn; A = a; B = b; Start = 1'b1;
      @(posedge Clk);
      #1 Start = 1'b0;
   endtask

   // Counts capture-relative edges until Done is seen, plus cycles with Busy high.
   task automatic wait_done(output int n, output int busy_cnt);
      n = 0;
      busy_cnt = 0;
      forever begin
         @(negedge Clk);
         if (Done) break;
         if (Busy) busy_cnt++;
         if (n >= 100) begin
            total++; bad++;
            $display("FAIL timeout: no Done within %0d cycles", n);
            break;
         end
         @(posedge Clk);
         n++;
      end
   endtask

   initial begin
      int n, bc, dcnt;
      vecs[0]  = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 33};
      vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0, 33};
      vecs[2]  = '{1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         1'b0, 33};
      vecs[3]  = '{1'b0, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5,         1'b1, 1};
      vecs[4]  = '{1'b1, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5,         1'b1, 1};
      vecs[5]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0, 33};
      vecs[6]  = '{1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000,  1'b0, 33};
      vecs[7]  = '{1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0,         1'b0, 33};
      vecs[8]  = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE,  1'b0, 33};
      vecs[9]  = '{1'b0, 32'd0,         32'd3,         32'd0,         32'd0,         1'b0, 33};
      vecs[10] = '{1'b1, 32'hFFFFFFF9,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFF9,  1'b1, 1};
      vecs[11] = '{1'b0, 32'd7,         32'd9,         32'd0,         32'd7,         1'b0, 33};
      vecs[12] = '{1'b0, 32'hFFFFFFFF,  32'h10,        32'h0FFFFFFF,  32'hF,         1'b0, 33};

      repeat (2) @(posedge Clk);
      @(negedge Clk);
      chk("rst_busy", {31'd0, Busy}, 32'd0);
      chk("rst_done", {31'd0, Done}, 32'd0);
      chk("rst_q", Quotient, 32'd0);
      chk("rst_r", Remainder, 32'd0);
      chk("rst_dz", {31'd0, DivByZero}, 32'd0);
      Rst = 1'b0;

      for (int i = 0; i < 13; i++) begin
         launch(vecs[i].sgn, vecs[i].a, vecs[i].b);
         // Scramble inputs after capture; result must not depend on them.
         A = 32'h1234_5678; B = 32'd0; Signed = ~vecs[i].sgn;
         wait_done(n, bc);
         $display("vec %0d: sgn=%0d a=%h b=%h -> q=%h r=%h dz=%0d lat=%0d busy=%0d",
                  i, vecs[i].sgn, vecs[i].a, vecs[i].b, Quotient, Remainder, DivByZero, n, bc);
         chk($sformatf("v%0d_q", i), Quotient, vecs[i].q);
         chk($sformatf("v%0d_r", i), Remainder, vecs[i].r);
         chk($sformatf("v%0d_dz", i), {31'd0, DivByZero}, {31'd0, vecs[i].dz});
         chk($sformatf("v%0d_lat", i), n, vecs[i].lat);
         chk($sformatf("v%0d_busy", i), bc, vecs[i].lat);
         @(negedge Clk);
         chk($sformatf("v%0d_pulse", i), {31'd0, Done}, 32'd0);
      end

      // Reset at iteration 10 aborts the divide and clears results.
      launch(1'b0, 32'd100, 32'd7);
      repeat (10) @(posedge Clk);
      @(negedge Clk);
      Rst = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      Rst = 1'b0;
      chk("abort_busy", {31'd0, Busy}, 32'd0);
      chk("abort_q", Quotient, 32'd0);
      chk("abort_r", Remainder, 32'd0);
      chk("abort_dz", {31'd0, DivByZero}, 32'd0);
      dcnt = 0;
      repeat (40) begin
         @(negedge Clk);
         if (Done || Busy) dcnt++;
      end
      chk("abort_no_done", dcnt, 0);
      $display("abort: activity cycles after reset=%0d", dcnt);

      // Start coincident with reset is dropped.
      @(negedge Clk);
      Rst = 1'b1; Start = 1'b1; A = 32'd9; B = 32'd3; Signed = 1'b0;
      @(posedge Clk);
      #1 Rst = 1'b0; Start = 1'b0;
      @(negedge Clk);
      chk("rst_start_busy", {31'd0, Busy}, 32'd0);

      launch(1'b0, 32'd100, 32'd7);
      wait_done(n, bc);
      $display("post-reset 100/7: q=%h r=%h lat=%0d", Quotient, Remainder, n);
      chk("post_q", Quotient, 32'd14);
      chk("post_r", Remainder, 32'd2);
      chk("post_lat", n, 33);

      // Start re-asserted at iteration 5 is ignored.
      launch(1'b0, 32'd1000, 32'd3);
      repeat (5) @(posedge Clk);
      #1 Start = 1'b1; A = 32'd1; B = 32'd1; Signed = 1'b1;
      @(posedge Clk);
      #1 Start = 1'b0;
      wait_done(n, bc);
      $display("busy-start 1000/3: q=%h r=%h", Quotient, Remainder);
      chk("ign_q", Quotient, 32'd333);
      chk("ign_r", Remainder, 32'd1);
      chk("ign_lat", n, 27);

      // Start held high through Done launches a back-to-back divide.
      @(negedge Clk);
      Signed = 1'b0; A = 32'd100; B = 32'd7; Start = 1'b1;
      @(posedge Clk);
      #1 A = 32'd50; B = 32'd5;
      wait_done(n, bc);
      chk("b2b_first_q", Quotient, 32'd14);
      chk("b2b_first_lat", n, 33);
      @(posedge Clk);
      #1 Start = 1'b0;
      @(negedge Clk);
      chk("b2b_busy", {31'd0, Busy}, 32'd1);
      chk("b2b_done_low", {31'd0, Done}, 32'd0);
      chk("b2b_hold_q", Quotient, 32'd14);
      @(posedge Clk);
      #1;
      wait_done(n, bc);
      $display("back-to-back 50/5: q=%h r=%h", Quotient, Remainder);
      chk("b2b_second_q", Quotient, 32'd10);
      chk("b2b_second_r", Remainder, 32'd0);
      chk("b2b_second_lat", n, 32);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
